// File: rtl/dmem_responder.sv
// Multicycle word-addressed data memory responder with configurable wait states.
// Accepts one read or write in IDLE, rejects misaligned or out-of-range addresses with an error completion.
module dmem_responder #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt;
  logic            we_q;
  logic            err_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH];
  logic            bad_req;

  // The full upper address is compared so that high bits are never wrapped into range.
  assign bad_req = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            wdata_q <= wdata;
            idx_q   <= addr[AW+1:2];
            err_q   <= bad_req;
            cnt     <= 4'(WAIT);
          end
        end
        S_WAIT: cnt <= cnt - 4'd1;
        S_ACCESS: begin
          if (!we_q) rdata <= mem[idx_q];
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset; a reset during ACCESS leaves no edge to commit on.
  always_ff @(posedge clock) begin
    if (state == S_ACCESS && we_q) mem[idx_q] <= wdata_q;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (bad_req)        state_nx = S_DONE;
          else if (WAIT == 0) state_nx = S_ACCESS;
          else                state_nx = S_WAIT;
        end
      end
      S_WAIT:   if (cnt <= 4'd1) state_nx = S_ACCESS;
      S_ACCESS: state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
    err  = (state == S_DONE) && err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WAITA = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, we;
  logic [31:0] addr, wdata, rdata;
  logic        busy, done, err;
  logic        req0, we0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        busy0, done0, err0;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT(WAITA)) u_dut (
    .clock(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_dut0 (
    .clock(clk), .reset_n(reset_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .busy(busy0), .done(done0), .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete transaction on the WAIT=2 instance, checked against the model.
  task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        bad;
    int unsigned lat;
    int unsigned exp_lat;
    logic [31:0] exp_r;
    bad     = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    exp_lat = bad ? 0 : WAITA + 1;
    exp_r   = (!bad && !w) ? model_mem[a >> 2] : model_rdata;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, 32'(err), 32'(bad));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_rdata"}, rdata, exp_r);
    if (!bad && w) model_mem[a >> 2] = d;
    if (!bad && !w) model_rdata = exp_r;
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] a, d, written;
    int unsigned sel, ndone;
    int last_done;
    logic prev_busy, cur_we;

    reset_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    model_rdata = '0;
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst0_rdata", rdata0, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) begin
      d = (i == 5) ? 32'd0 : ($urandom | 32'd1);
      xact("init", 1'b1, 32'(i) << 2, d);
    end

    xact("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF);
    xact("rd10", 1'b0, 32'h10, 32'h0);
    check("rd10_val", rdata, 32'hDEAD_BEEF);

    xact("mis6", 1'b0, 32'h6, 32'h0);
    check("mis6_keep", rdata, 32'hDEAD_BEEF);

    xact("oor100", 1'b1, 32'h100, 32'h5555_AAAA);
    xact("rd0", 1'b0, 32'h0, 32'h0);
    xact("oorhi", 1'b1, 32'h8000_0000, 32'h1111_2222);
    xact("rd0b", 1'b0, 32'h0, 32'h0);

    // Ignored request while busy
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("ign_busy", 32'(busy), 32'd1);
    req = 1'b1; we = 1'b1; addr = 32'h24; wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    req = 1'b0;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("ign_ndone", ndone, 32'd1);
    model_mem[8] = 32'h1234_5678;
    xact("ign_rd24", 1'b0, 32'h24, 32'h0);
    xact("ign_rd20", 1'b0, 32'h20, 32'h0);

    // Reset mid-WAIT of a write to word 5 (currently 0)
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h14; wdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("rstw_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_done", 32'(done), 32'd0);
    check("rstw_err", 32'(err), 32'd0);
    check("rstw_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_rdata = '0;
    xact("rstw_rd14", 1'b0, 32'h14, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (sel == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'h100 + (32'($urandom_range(0, 1000)) << 2);
      else               a = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
      xact("rand", 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Back-to-back on the zero-wait instance with req held high
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; wdata0 = $urandom;
    prev_busy = 1'b0; cur_we = 1'b0; written = '0; d = '0;
    last_done = -1; ndone = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      if (busy0 && !prev_busy) begin
        cur_we = we0;
        d = wdata0;
        we0 = ~we0;
        wdata0 = $urandom;
      end
      if (done0) begin
        if (last_done >= 0) check("b2b_period", 32'(c - last_done), 32'd3);
        last_done = c;
        check("b2b_err", 32'(err0), 32'd0);
        if (cur_we) written = d;
        else        check("b2b_rdata", rdata0, written);
        ndone++;
      end
      prev_busy = busy0;
    end
    req0 = 1'b0;
    check("b2b_ndone", ndone, 32'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
